// File: rtl/array_refresh_sched.sv
// Array-side scheduler: zero-latency frame pass-through with periodic refresh
// inserted only at frame boundaries, postponed under traffic up to a limit.
module array_refresh_sched #(
  parameter int unsigned ARRAY_FRAME_DATA_WIDTH = 89,
  parameter int unsigned TREFI                  = 7800,
  parameter int unsigned TRFC                   = 350,
  parameter int unsigned MAX_POSTPONE           = 8,
  parameter int unsigned PEND_WIDTH             = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mc_en,
  input  logic                              arb_frame_valid,
  output logic                              arb_frame_ready,
  input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] arb_frame_data,
  output logic                              array_frame_valid,
  input  logic                              array_frame_ready,
  output logic [ARRAY_FRAME_DATA_WIDTH-1:0] array_frame_data,
  output logic                              ref_req,
  input  logic                              ref_ack,
  output logic [PEND_WIDTH-1:0]             ref_pending,
  output logic                              ref_busy,
  output logic                              ref_overflow,
  output logic                              proto_err
);

  localparam int unsigned TMR_W   = $clog2(TREFI);
  localparam int unsigned CNT_W   = $clog2(TRFC + 1);
  localparam int unsigned EOF_BIT = ARRAY_FRAME_DATA_WIDTH - 1;
  localparam int unsigned SOF_BIT = ARRAY_FRAME_DATA_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, FRAME, REF, RECOV} state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PEND_WIDTH-1:0] pending_q, pending_d;
  logic                  ref_req_q, ref_req_d;
  logic                  ref_busy_q, ref_busy_d;
  logic                  ref_overflow_q, ref_overflow_d;
  logic                  proto_err_q, proto_err_d;

  logic tick, at_max, take_ref, pass, beat_acc, ack_ok, sof, eof;

  always_comb begin
    tick     = mc_en && (timer_q == TMR_W'(TREFI - 1));
    at_max   = (pending_q == PEND_WIDTH'(MAX_POSTPONE));
    take_ref = (state_q == IDLE) && mc_en && (pending_q != '0) && (!arb_frame_valid || at_max);
    pass     = ((state_q == IDLE) && !take_ref) || (state_q == FRAME);
    beat_acc = arb_frame_valid && array_frame_ready && pass;
    ack_ok   = (state_q == REF) && ref_ack;
    sof      = arb_frame_data[SOF_BIT];
    eof      = arb_frame_data[EOF_BIT];

    state_d        = state_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    ref_overflow_d = ref_overflow_q;
    proto_err_d    = proto_err_q;

    if (!mc_en || tick) timer_d = '0;
    else                timer_d = timer_q + TMR_W'(1);

    // Simultaneous tick and ack cancel; a tick at saturation is lost and flagged.
    if (tick && at_max) ref_overflow_d = 1'b1;
    if (tick && !ack_ok) begin
      if (!at_max) pending_d = pending_q + PEND_WIDTH'(1);
    end else if (ack_ok && !tick) begin
      pending_d = pending_q - PEND_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (take_ref) begin
          state_d = REF;
        end else if (beat_acc) begin
          if (!sof)      proto_err_d = 1'b1;
          else if (!eof) state_d     = FRAME;
        end
      end
      FRAME: begin
        if (beat_acc) begin
          if (eof)      state_d     = IDLE;
          else if (sof) proto_err_d = 1'b1;
        end
      end
      REF: begin
        if (ref_ack) begin
          cnt_d   = CNT_W'(TRFC - 1);
          state_d = RECOV;
        end
      end
      RECOV: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    ref_req_d  = (state_d == REF);
    ref_busy_d = (state_d == REF) || (state_d == RECOV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      cnt_q          <= '0;
      pending_q      <= '0;
      ref_req_q      <= 1'b0;
      ref_busy_q     <= 1'b0;
      ref_overflow_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      ref_req_q      <= ref_req_d;
      ref_busy_q     <= ref_busy_d;
      ref_overflow_q <= ref_overflow_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign array_frame_valid = arb_frame_valid & pass;
  assign arb_frame_ready   = array_frame_ready & pass;
  assign array_frame_data  = arb_frame_data;
  assign ref_req           = ref_req_q;
  assign ref_pending       = pending_q;
  assign ref_busy          = ref_busy_q;
  assign ref_overflow      = ref_overflow_q;
  assign proto_err         = proto_err_q;

endmodule

// File: tb/tb_array_refresh_sched.sv
// Bench for array_refresh_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_array_refresh_sched;

  localparam int unsigned DW    = 89;
  localparam int unsigned TREFI = 16;
  localparam int unsigned TRFC  = 4;
  localparam int unsigned MAXP  = 2;
  localparam int unsigned PW    = 4;

  logic          clk = 1'b0;
  logic          rst, mc_en, arb_frame_valid, arb_frame_ready;
  logic [DW-1:0] arb_frame_data, array_frame_data;
  logic          array_frame_valid, array_frame_ready;
  logic          ref_req, ref_ack, ref_busy, ref_overflow, proto_err;
  logic [PW-1:0] ref_pending;

  int total = 0;
  int bad   = 0;

  array_refresh_sched #(
    .ARRAY_FRAME_DATA_WIDTH(DW), .TREFI(TREFI), .TRFC(TRFC),
    .MAX_POSTPONE(MAXP), .PEND_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .mc_en(mc_en),
    .arb_frame_valid(arb_frame_valid), .arb_frame_ready(arb_frame_ready),
    .arb_frame_data(arb_frame_data),
    .array_frame_valid(array_frame_valid), .array_frame_ready(array_frame_ready),
    .array_frame_data(array_frame_data),
    .ref_req(ref_req), .ref_ack(ref_ack), .ref_pending(ref_pending),
    .ref_busy(ref_busy), .ref_overflow(ref_overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat(input logic s, input logic e);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    r[88] = e;
    r[87] = s;
    return r[DW-1:0];
  endfunction

  // Behavioural model: owed-refresh count, frame/wait/recovery flags, cycle countdown.
  int m_tmr, m_owed, m_block;
  bit m_ovf, m_perr, m_in_frame, m_wait;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_tmr = 0; m_owed = 0; m_block = 0;
        m_ovf = 0; m_perr = 0; m_in_frame = 0; m_wait = 0;
        chk("rst_req", DW'(ref_req), '0);
        chk("rst_pending", DW'(ref_pending), '0);
      end else begin
        bit idle, take, pass, acc, tick, ackd, s, e;
        idle = !m_in_frame && !m_wait && (m_block == 0);
        take = idle && mc_en && (m_owed > 0) && (!arb_frame_valid || m_owed == MAXP);
        pass = (idle && !take) || m_in_frame;
        acc  = arb_frame_valid && array_frame_ready && pass;
        s    = arb_frame_data[87];
        e    = arb_frame_data[88];
        chk("m_ref_req", DW'(ref_req), DW'(m_wait));
        chk("m_ref_busy", DW'(ref_busy), DW'(m_wait || m_block > 0));
        chk("m_pending", DW'(ref_pending), DW'(m_owed));
        chk("m_overflow", DW'(ref_overflow), DW'(m_ovf));
        chk("m_proto_err", DW'(proto_err), DW'(m_perr));
        chk("m_arr_valid", DW'(array_frame_valid), DW'(arb_frame_valid && pass));
        chk("m_arb_ready", DW'(arb_frame_ready), DW'(array_frame_ready && pass));
        chk("m_data", array_frame_data, arb_frame_data);

        tick  = mc_en && (m_tmr == TREFI - 1);
        m_tmr = mc_en ? (m_tmr + 1) % TREFI : 0;
        ackd  = m_wait && ref_ack;
        if (tick && m_owed == MAXP) m_ovf = 1;
        if (tick && !ackd) m_owed = (m_owed < MAXP) ? m_owed + 1 : m_owed;
        else if (ackd && !tick) m_owed = m_owed - 1;

        if (m_wait) begin
          if (ref_ack) begin m_wait = 0; m_block = TRFC; end
        end else if (m_block > 0) begin
          m_block--;
        end else if (m_in_frame) begin
          if (acc) begin
            if (e) m_in_frame = 0;
            else if (s) m_perr = 1;
          end
        end else if (take) begin
          m_wait = 1;
        end else if (acc) begin
          if (!s) m_perr = 1;
          else if (!e) m_in_frame = 1;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; mc_en = 1'b0; arb_frame_valid = 1'b0; arb_frame_data = '0;
    array_frame_ready = 1'b1; ref_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_busy", DW'(ref_busy), '0);
    chk("reset_ovf", DW'(ref_overflow), '0);
    chk("reset_perr", DW'(proto_err), '0);

    // Idle refresh: timer starts now, tick on 16th cycle, ref_req one cycle after take.
    mc_en = 1'b1;
    n = 0;
    while (!ref_req && n < 40) begin step(); n++; end
    chk("idle_req_latency", DW'(n), DW'(17));
    chk("idle_pending_1", DW'(ref_pending), DW'(1));
    chk("idle_blocked_ref", DW'(arb_frame_ready), '0);
    step();
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("idle_pending_0", DW'(ref_pending), '0);
    n = 0;
    while (!arb_frame_ready && n < 20) begin n++; step(); end
    chk("idle_recov_len", DW'(n), DW'(TRFC));

    // Open a frame, starve it: pending saturates and overflow sticks.
    arb_frame_valid = 1'b1; arb_frame_data = beat(1'b1, 1'b0);
    step();
    arb_frame_valid = 1'b0;
    repeat (48) step();
    chk("ovf_pending_sat", DW'(ref_pending), DW'(MAXP));
    chk("ovf_flag", DW'(ref_overflow), DW'(1));
    chk("ovf_no_req_in_frame", DW'(ref_req), '0);

    // Close the frame with valid held: saturation forces the refresh anyway.
    arb_frame_valid = 1'b1; arb_frame_data = beat(1'b0, 1'b1);
    step();
    arb_frame_data = beat(1'b1, 1'b0);
    chk("forced_blocks_traffic", DW'(arb_frame_ready), '0);
    step();
    chk("forced_req", DW'(ref_req), DW'(1));
    chk("ovf_sticky", DW'(ref_overflow), DW'(1));

    // Asynchronous reset while a request is outstanding.
    #1 rst = 1'b1;
    #1;
    chk("async_req", DW'(ref_req), '0);
    chk("async_pending", DW'(ref_pending), '0);
    chk("async_ovf", DW'(ref_overflow), '0);
    chk("async_busy", DW'(ref_busy), '0);
    arb_frame_valid = 1'b0;
    step();
    rst = 1'b0; mc_en = 1'b0;

    // Beat without sof in IDLE flags a protocol error.
    arb_frame_valid = 1'b1; arb_frame_data = beat(1'b0, 1'b0);
    step();
    arb_frame_valid = 1'b0;
    chk("proto_err_set", DW'(proto_err), DW'(1));

    // Randomized traffic; the model checker covers every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst               = ($urandom_range(0, 399) == 0);
      mc_en             = ($urandom_range(0, 19) != 0);
      arb_frame_valid   = ($urandom_range(0, 9) < 8);
      array_frame_ready = ($urandom_range(0, 3) != 0);
      arb_frame_data    = beat($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      ref_ack           = ref_req && ($urandom_range(0, 1) == 1);
      step();
    end
    rst = 1'b0; ref_ack = 1'b0; arb_frame_valid = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
